// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state type and default register file geometry.
package regfile_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: read/write/clear bus between the core pipeline and the register file.
interface regfile_if import regfile_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                wr_ready;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, wr_ready, clr_busy, clr_done
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, wr_ready, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequences a one-register-per-cycle bulk clear with busy/done handshake.
module regfile_clr_fsm import regfile_pkg::*; #(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req_i,
    output logic          clr_busy_o,
    output logic          clr_done_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);
    clr_state_t    state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (clr_req_i) begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                CLEAR: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(NREGS - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clr_busy_o = busy_q;
    assign clr_done_o = done_q;
    assign clr_we_o   = state_q == CLEAR;
    assign clr_addr_o = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass and sequenced bulk clear.
module regfile_mp import regfile_pkg::*; #(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    regfile_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic                clr_we;
    logic [AW-1:0]       clr_addr;
    logic                clr_busy;
    logic                wr_acc;
    logic [NRD*XLEN-1:0] rd_data;

    regfile_clr_fsm #(.NREGS(NREGS)) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (bus.clr_req),
        .clr_busy_o (clr_busy),
        .clr_done_o (bus.clr_done),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign wr_acc       = bus.wr_en && !clr_busy && !(ZERO_REG != 0 && bus.wr_addr == '0);
    assign bus.wr_ready = !clr_busy;
    assign bus.clr_busy = clr_busy;
    assign bus.rd_data  = rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else if (clr_we) regs_q[clr_addr] <= '0;
        else if (wr_acc) regs_q[bus.wr_addr] <= bus.wr_data;
    end

    // wr_acc is already false while busy, so dropped writes never bypass
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] a;
        assign a = bus.rd_addr[p*AW +: AW];
        assign rd_data[p*XLEN +: XLEN] = (ZERO_REG != 0 && a == '0) ? '0 :
                                         (wr_acc && bus.wr_addr == a) ? bus.wr_data : regs_q[a];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp covering bypass, x0, bulk clear and async reset.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    typedef struct {
        string           tag;
        int              p;
        logic [XLEN-1:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    exp_t sb[$];
    int   ntests = 0;
    int   nfail = 0;
    int   nbusy;
    int   ndone;

    always #5 clk = ~clk;

    regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_rd(input string tag, input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] v);
        bus.rd_addr[p*AW +: AW] = a;
        sb.push_back('{tag, p, v});
    endtask

    task automatic check_sb();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, bus.rd_data[e.p*XLEN +: XLEN], e.v);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(posedge clk);
        #1 bus.clr_req = 1'b0;
    endtask

    initial begin
        int ra[3] = '{0, 5, 31};
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.clr_req = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_rd("rst_rd_p0", 0, AW'(ra[i]), '0);
            exp_rd("rst_rd_p1", 1, AW'(ra[i]), '0);
            check_sb();
        end
        chk("rst_wr_ready", 32'(bus.wr_ready), 1);
        chk("rst_busy", 32'(bus.clr_busy), 0);
        chk("rst_done", 32'(bus.clr_done), 0);
        @(negedge clk) rst_n = 1'b1;

        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hDEADBEEF;
        exp_rd("byp_p0", 0, 5'd7, 32'hDEADBEEF);
        exp_rd("byp_p1", 1, 5'd7, 32'hDEADBEEF);
        check_sb();
        @(negedge clk);
        bus.wr_en = 1'b0;
        exp_rd("x7_stored", 0, 5'd7, 32'hDEADBEEF);
        check_sb();

        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h12345678;
        exp_rd("x0_byp", 0, 5'd0, '0);
        check_sb();
        @(negedge clk);
        bus.wr_en = 1'b0;
        exp_rd("x0_stored", 1, 5'd0, '0);
        check_sb();

        for (int i = 0; i < NREGS; i++) wr(AW'(i), XLEN'(i + 1));
        @(negedge clk);
        exp_rd("pre_x10", 0, 5'd10, 32'd11);
        exp_rd("pre_x31", 1, 5'd31, 32'd32);
        check_sb();
        clr_pulse();
        nbusy = 0;
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 4) begin
                exp_rd("clr_e4_x3", 0, 5'd3, '0);
                exp_rd("clr_e4_x10", 1, 5'd10, 32'd11);
            end
            if (k == 5) begin
                bus.wr_en = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 32'hAAAA;
                exp_rd("busy_no_byp", 1, 5'd20, 32'd21);
            end
            if (k == 6) bus.wr_en = 1'b0;
            check_sb();
            if (k == 5) chk("busy_wr_ready", 32'(bus.wr_ready), 0);
            if (bus.clr_busy) nbusy++;
            if (bus.clr_done) begin
                ndone++;
                chk("done_cycle", k, 32);
            end
            if (!bus.clr_busy) break;
        end
        chk("busy_cycles", nbusy, 33);
        chk("done_pulses", ndone, 1);
        chk("post_wr_ready", 32'(bus.wr_ready), 1);
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            exp_rd("post_clr_p0", 0, AW'(i), '0);
            exp_rd("post_clr_p1", 1, AW'(NREGS - 1 - i), '0);
            check_sb();
        end

        wr(5'd31, 32'd77);
        wr(5'd20, 32'h20);
        clr_pulse();
        for (int k = 0; k <= 10; k++) @(negedge clk);
        #1 chk("busy_pre_rst", 32'(bus.clr_busy), 1);
        rst_n = 1'b0;
        #1 chk("busy_async_rst", 32'(bus.clr_busy), 0);
        chk("ready_async_rst", 32'(bus.wr_ready), 1);
        exp_rd("rst_mid_x31", 0, 5'd31, '0);
        exp_rd("rst_mid_x20", 1, 5'd20, '0);
        check_sb();
        @(negedge clk) rst_n = 1'b1;

        wr(5'd1, 32'h11);
        wr(5'd2, 32'h22);
        clr_pulse();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 1) exp_rd("restart_e1_x1", 0, 5'd1, 32'h11);
            if (k == 2) begin
                exp_rd("restart_e2_x1", 0, 5'd1, '0);
                exp_rd("restart_e2_x2", 1, 5'd2, 32'h22);
            end
            check_sb();
            if (k == 0) chk("restart_busy", 32'(bus.clr_busy), 1);
            if (!bus.clr_busy) break;
        end
        chk("restart_idle", 32'(bus.clr_busy), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
